// File: rtl/axi_dma_rd_a.sv
// Aligned CDMA AXI read engine: splits (addr, len) commands into INCR read bursts
// and forwards the returned R beats unchanged onto an AXI4-Stream master.
module axi_dma_rd_a #(
    parameter int BURST_LEN       = 16,
    parameter int DATA_BITS       = 512,
    parameter int ADDR_BITS       = 64,
    parameter int ID_BITS         = 4,
    parameter int LEN_BITS        = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   ctrl_valid,
    output logic                   stat_ready,
    input  logic [ADDR_BITS-1:0]   ctrl_addr,
    input  logic [LEN_BITS-1:0]    ctrl_len,
    input  logic                   ctrl_ctl,
    output logic                   stat_done,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_BITS-1:0]   araddr,
    output logic [ID_BITS-1:0]     arid,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arlock,
    output logic [3:0]             arcache,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [DATA_BITS-1:0]   rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic [ID_BITS-1:0]     rid,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [DATA_BITS-1:0]   axis_out_tdata,
    output logic [DATA_BITS/8-1:0] axis_out_tkeep,
    output logic                   axis_out_tlast
);

    localparam int AXI_DATA_BYTES = DATA_BITS / 8;
    localparam int LOG_DATA_LEN   = $clog2(AXI_DATA_BYTES);
    localparam int LOG_BURST_LEN  = $clog2(BURST_LEN);
    localparam int FULL_W         = LEN_BITS - LOG_DATA_LEN - LOG_BURST_LEN;
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W          = $clog2(MAX_OUTSTANDING);

    localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(BURST_LEN * AXI_DATA_BYTES);
    localparam logic [CNT_W-1:0]     Q_MAX     = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state, state_nxt;

    logic [FULL_W-1:0]        len_full;
    logic [LOG_BURST_LEN-1:0] len_part;
    logic [ADDR_BITS-1:0]     cur_addr;
    logic [FULL_W-1:0]        txn_cnt;
    logic [LOG_BURST_LEN-1:0] final_len;
    logic                     cmd_ctl;
    logic                     cmd_last;
    logic                     accept;
    logic                     ar_hs;
    logic                     pop;
    logic [1:0]               q_mem [MAX_OUTSTANDING];
    logic [CNT_W-1:0]         q_count;
    logic [IDX_W-1:0]         head_idx;
    logic [1:0]               head;
    logic                     unused_ok;

    assign len_full = ctrl_len[LEN_BITS-1:LOG_DATA_LEN+LOG_BURST_LEN];
    assign len_part = ctrl_len[LOG_DATA_LEN +: LOG_BURST_LEN];
    assign accept   = ctrl_valid & stat_ready;
    assign ar_hs    = arvalid & arready;
    assign cmd_last = (txn_cnt == '0);
    assign pop      = rvalid & axis_out_tready & rlast & (q_count != '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stat_ready = 1'b0;
        case (state)
            IDLE: begin
                stat_ready = 1'b1;
                if (ctrl_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs && cmd_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers: txn_cnt holds remaining AR transactions minus one
    always_ff @(posedge aclk) begin
        if (accept) begin
            cur_addr  <= {ctrl_addr[ADDR_BITS-1:LOG_DATA_LEN], LOG_DATA_LEN'(0)};
            txn_cnt   <= (len_part != '0) ? len_full : len_full - FULL_W'(1);
            final_len <= len_part - LOG_BURST_LEN'(1);
            cmd_ctl   <= ctrl_ctl;
        end else if (ar_hs) begin
            cur_addr <= cur_addr + ADDR_STEP;
            txn_cnt  <= txn_cnt - FULL_W'(1);
        end
    end

    // A burst is only requested while the burst-info queue has room for it
    always_ff @(posedge aclk) begin
        if (areset) begin
            arvalid <= 1'b0;
        end else if (ar_hs) begin
            arvalid <= 1'b0;
        end else if ((state == ISSUE) && !arvalid && (q_count < Q_MAX)) begin
            arvalid <= 1'b1;
        end
    end

    assign araddr  = cur_addr;
    assign arid    = '0;
    assign arlen   = cmd_last ? 8'(final_len) : 8'(BURST_LEN - 1);
    assign arsize  = 3'(LOG_DATA_LEN);
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'b0011;

    // Burst-info shift queue: newest at index 0, oldest at q_count-1
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            for (int i = MAX_OUTSTANDING - 1; i > 0; i--) begin
                q_mem[i] <= q_mem[i-1];
            end
            q_mem[0] <= {cmd_last, cmd_last & cmd_ctl};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            q_count <= '0;
        end else if (ar_hs && !pop) begin
            q_count <= q_count + CNT_W'(1);
        end else if (!ar_hs && pop) begin
            q_count <= q_count - CNT_W'(1);
        end
    end

    assign head_idx = IDX_W'(q_count - CNT_W'(1));
    assign head     = q_mem[head_idx];

    assign axis_out_tvalid = rvalid;
    assign rready          = axis_out_tready;
    assign axis_out_tdata  = rdata;
    assign axis_out_tkeep  = '1;
    assign axis_out_tlast  = rlast & head[1];
    assign stat_done       = pop & head[0];

    // Response status, ID and sub-beat address/length bits carry no meaning here
    assign unused_ok = ^{rresp, rid, ctrl_len[LOG_DATA_LEN-1:0], ctrl_addr[LOG_DATA_LEN-1:0]};

endmodule
